decoder38_scan: RTL and testbench

- Registered 3-to-8 one-hot decoder with a built-in scan sequencer.
- It is the inverse of the lab's 8-3 encoder.
- Direct mode: decodes a 3-bit code presented with a valid strobe.
- Scan mode: walks index 0..7 at a prescaled rate to drive one-hot digit/row selects, e.g. the 8-digit seven-segment display on the lab board.

---
 rtl/decoder38_scan.sv | 113 +++++++++++
 tb/tb_decoder38_scan.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder38_scan.sv
// -----------------------------------------------------------------------------
// decoder38_scan
//
// Registered 3-to-8 one-hot decoder with a built-in scan sequencer. It is the
// inverse of the lab's 8-to-3 encoder.
//   Direct mode (iMode = 0): a code on iData, qualified by iValid, is decoded
//     onto oData one clock later.
//   Scan mode   (iMode = 1): the index walks 0..7 (wrapping), each index held
//     for DIV clocks. This drives one-hot digit/row selects such as the
//     8-digit seven-segment display on the lab board.
//
// Parameters
//   DIV     clocks per scan step, must be >= 1
//
// Ports
//   clk     system clock, rising edge
//   rst     asynchronous reset, active-high
//   iEna    block enable; 0 blanks oData on the next edge, index/prescaler hold
//   iMode   0 = direct decode, 1 = scan
//   iValid  direct mode: iData is valid this cycle
//   iData   code to decode in direct mode
//   oData   one-hot select (bit n high <=> index n), registered
//   oIndex  index currently decoded onto oData, registered
//   oValid  one-cycle pulse when oIndex/oData take a new index, registered
// -----------------------------------------------------------------------------
module decoder38_scan #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iEna,
  input  logic       iMode,
  input  logic       iValid,
  input  logic [2:0] iData,
  output logic [7:0] oData,
  output logic [2:0] oIndex,
  output logic       oValid
);

  // A DIV of 1 still needs a 1-bit counter; it simply never leaves 0.
  localparam int            CW   = (DIV <= 1) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] presc,   presc_nxt;
  logic          loaded,  loaded_nxt;
  logic [7:0]    data_nxt;
  logic [2:0]    index_nxt;
  logic          valid_nxt;

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    onehot = 8'h01 << idx;
  endfunction

  // Next-state logic. oData is always rebuilt from the index (or zero), so it
  // can never drift into a multi-hot pattern.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    presc_nxt  = presc;
    loaded_nxt = loaded;
    index_nxt  = oIndex;
    data_nxt   = 8'h00;
    valid_nxt  = 1'b0;

    if (iEna) begin
      if (!iMode) begin
        // Direct decode: the prescaler parks at 0 so a later switch into scan
        // mode always gives the current index a full DIV clocks.
        presc_nxt = '0;
        if (iValid) begin
          index_nxt  = iData;
          data_nxt   = onehot(iData);
          valid_nxt  = 1'b1;
          loaded_nxt = 1'b1;
        end else begin
          // Nothing decoded yet since reset: stay blank rather than showing
          // the reset index as if it had been requested.
          data_nxt = loaded ? onehot(oIndex) : 8'h00;
        end
      end else begin
        loaded_nxt = 1'b1;
        if (presc == LAST) begin
          presc_nxt = '0;
          index_nxt = oIndex + 3'd1;
          data_nxt  = onehot(oIndex + 3'd1);
          valid_nxt = 1'b1;
        end else begin
          presc_nxt = presc + CW'(1);
          data_nxt  = onehot(oIndex);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      loaded <= 1'b0;
      oData  <= 8'h00;
      oIndex <= 3'd0;
      oValid <= 1'b0;
    end else begin
      presc  <= presc_nxt;
      loaded <= loaded_nxt;
      oData  <= data_nxt;
      oIndex <= index_nxt;
      oValid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_decoder38_scan.sv
// -----------------------------------------------------------------------------
// tb_decoder38_scan
//
// Self-checking bench for decoder38_scan (DIV = 4). Inputs change only in the
// middle of a clock period; outputs are sampled 1 ns after the rising edge.
// A reference model counts enabled scan clocks and advances the index every
// DIV of them; direct mode simply records the last accepted code.
// -----------------------------------------------------------------------------
module tb_decoder38_scan;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       iEna;
  logic       iMode;
  logic       iValid;
  logic [2:0] iData;
  logic [7:0] oData;
  logic [2:0] oIndex;
  logic       oValid;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_idx;
  int         m_ticks;   // enabled scan clocks since scanning (re)started
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_loaded;

  decoder38_scan #(.DIV(DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .iEna   (iEna),
    .iMode  (iMode),
    .iValid (iValid),
    .iData  (iData),
    .oData  (oData),
    .oIndex (oIndex),
    .oValid (oValid)
  );

  always #5 clk = ~clk;

  // Structural invariant, checked on every falling edge for the whole run.
  always @(negedge clk) begin
    checks++;
    if ($isunknown({oData, oIndex, oValid}) || ($countones(oData) > 1) ||
        ((oData != 8'h00) && (oData != (8'h01 << oIndex)))) begin
      errors++;
      $display("FAIL invariant: oData=%h oIndex=%0d oValid=%b, required 00 or one-hot of oIndex",
               oData, oIndex, oValid);
    end
  end

  // Reference model: one rising edge using the inputs present at that edge.
  task automatic model_edge();
    if (rst) begin
      m_idx = 0; m_ticks = 0; m_data = 8'h00; m_valid = 1'b0; m_loaded = 1'b0;
    end else if (!iEna) begin
      m_data  = 8'h00;
      m_valid = 1'b0;
    end else if (!iMode) begin
      m_ticks = 0;
      m_valid = iValid;
      if (iValid) begin
        m_idx    = int'(iData);
        m_loaded = 1'b1;
      end
      m_data = m_loaded ? 8'(1 << m_idx) : 8'h00;
    end else begin
      m_loaded = 1'b1;
      m_ticks++;
      m_valid = (m_ticks % DIV) == 0;
      if (m_valid) m_idx = (m_idx + 1) % 8;
      m_data = 8'(1 << m_idx);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; iEna = 1'b1; iMode = 1'b0; iValid = 1'b0; iData = 3'd0;
    repeat (2) step();
    #3 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({oData, oIndex, oValid} !== 12'h000) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got data=%h idx=%0d vld=%b, required 00/0/0",
                 i, oData, oIndex, oValid);
      end
    end
  endtask

  task automatic test_direct_back_to_back();
    logic [2:0] codes [4] = '{3'd5, 3'd0, 3'd7, 3'd7};
    logic [7:0] exp_d [4] = '{8'h20, 8'h01, 8'h80, 8'h80};
    for (int i = 0; i < 4; i++) begin
      iValid = 1'b1; iData = codes[i];
      step();
      checks++;
      if (oData !== exp_d[i] || oIndex !== codes[i] || oValid !== 1'b1) begin
        errors++;
        $display("FAIL direct[%0d]: got data=%h idx=%0d vld=%b, required %h/%0d/1",
                 i, oData, oIndex, oValid, exp_d[i], codes[i]);
      end
    end
    iValid = 1'b0;
    step();
    checks++;
    if (oData !== 8'h80 || oIndex !== 3'd7 || oValid !== 1'b0) begin
      errors++;
      $display("FAIL direct_hold: got data=%h idx=%0d vld=%b, required 80/7/0",
               oData, oIndex, oValid);
    end
  endtask

  task automatic test_scan();
    int   pulses = 0;
    int   gap = 0;
    bit   saw_wrap = 1'b0;
    logic [2:0] prev_idx = oIndex;
    iMode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if ({oData, oIndex, oValid} !== {m_data, 3'(m_idx), m_valid}) begin
        errors++;
        $display("FAIL scan[%0d]: got data=%h idx=%0d vld=%b, required %h/%0d/%b",
                 i, oData, oIndex, oValid, m_data, m_idx, m_valid);
      end
      gap++;
      if (oValid) begin
        if (pulses > 0) begin
          checks++;
          if (gap != DIV) begin
            errors++;
            $display("FAIL scan_period: got %0d clocks between steps, required %0d", gap, DIV);
          end
        end
        if (prev_idx == 3'd7 && oIndex == 3'd0 && oData == 8'h01) saw_wrap = 1'b1;
        pulses++;
        gap = 0;
      end
      prev_idx = oIndex;
    end
    checks++;
    if (pulses != 10 || !saw_wrap) begin
      errors++;
      $display("FAIL scan_count: got %0d steps wrap=%b, required 10 steps wrap=1", pulses, saw_wrap);
    end
  endtask

  task automatic test_enable_gating();
    int n = 0;
    while (!(oValid && oIndex == 3'd3) && n < 40) begin step(); n++; end
    checks++;
    if (!(oValid && oIndex == 3'd3)) begin
      errors++;
      $display("FAIL enable_seek: index 3 not reached in 40 clocks, got idx=%0d", oIndex);
      return;
    end
    iEna = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (oData !== 8'h00 || oIndex !== 3'd3 || oValid !== 1'b0) begin
        errors++;
        $display("FAIL enable_off[%0d]: got data=%h idx=%0d vld=%b, required 00/3/0",
                 i, oData, oIndex, oValid);
      end
    end
    iEna = 1'b1;
    step();
    checks++;
    if (oData !== 8'h08 || oValid !== 1'b0) begin
      errors++;
      $display("FAIL enable_on: got data=%h vld=%b, required 08/0", oData, oValid);
    end
    n = 1;
    while (oIndex !== 3'd4 && n < 20) begin step(); n++; end
    checks++;
    if (n != 4 || oData !== 8'h10 || oValid !== 1'b1) begin
      errors++;
      $display("FAIL enable_resume: got index 4 after %0d clocks data=%h, required 4 clocks data=10",
               n, oData);
    end
  endtask

  task automatic test_mode_switch();
    int n = 0;
    while (!(oValid && oIndex == 3'd6) && n < 40) begin step(); n++; end
    checks++;
    if (!(oValid && oIndex == 3'd6)) begin
      errors++;
      $display("FAIL mode_seek: index 6 not reached in 40 clocks, got idx=%0d", oIndex);
      return;
    end
    iMode = 1'b0;
    step();
    checks++;
    if (oData !== 8'h40 || oIndex !== 3'd6 || oValid !== 1'b0) begin
      errors++;
      $display("FAIL mode_to_direct: got data=%h idx=%0d vld=%b, required 40/6/0",
               oData, oIndex, oValid);
    end
    iValid = 1'b1; iData = 3'd2;
    step();
    checks++;
    if (oData !== 8'h04 || oIndex !== 3'd2 || oValid !== 1'b1) begin
      errors++;
      $display("FAIL mode_direct_load: got data=%h idx=%0d vld=%b, required 04/2/1",
               oData, oIndex, oValid);
    end
    iValid = 1'b0; iMode = 1'b1;
    n = 0;
    do begin step(); n++; end while (oIndex !== 3'd3 && n < 20);
    checks++;
    if (n != DIV || oData !== 8'h08) begin
      errors++;
      $display("FAIL mode_to_scan: got index 3 after %0d clocks data=%h, required %0d clocks data=08",
               n, oData, DIV);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    iEna = 1'b1; iMode = 1'b1; iValid = 1'b0;
    repeat (5) step();
    #3 rst = 1'b1;
    m_idx = 0; m_ticks = 0; m_data = 8'h00; m_valid = 1'b0; m_loaded = 1'b0;
    #1;
    checks++;
    if ({oData, oIndex, oValid} !== 12'h000) begin
      errors++;
      $display("FAIL async_reset: got data=%h idx=%0d vld=%b, required 00/0/0 immediately",
               oData, oIndex, oValid);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({oData, oIndex, oValid} !== 12'h000) begin
        errors++;
        $display("FAIL reset_held[%0d]: got data=%h idx=%0d vld=%b, required 00/0/0",
                 i, oData, oIndex, oValid);
      end
    end
    #3 rst = 1'b0;
    do begin step(); n++; end while (oIndex !== 3'd1 && n < 20);
    checks++;
    if (n != DIV || oData !== 8'h02 || oValid !== 1'b1) begin
      errors++;
      $display("FAIL reset_resume: got index 1 after %0d clocks data=%h, required %0d clocks data=02",
               n, oData, DIV);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      iEna   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) iMode = ~iMode;
      iValid = 1'($urandom_range(0, 1));
      iData  = 3'($urandom);
      step();
      checks++;
      if ({oData, oIndex, oValid} !== {m_data, 3'(m_idx), m_valid}) begin
        errors++;
        $display("FAIL random[%0d]: got data=%h idx=%0d vld=%b, required %h/%0d/%b",
                 i, oData, oIndex, oValid, m_data, m_idx, m_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct_back_to_back();
    test_scan();
    test_enable_gating();
    test_mode_switch();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
